ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_if.sv | 31 +++
 rtl/ifu.sv | 85 ++++++++
 tb/tb_ifu.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff and redirect.
interface ifu_if #(
  parameter int PC_W = 64
);
  logic            req_valid_o;
  logic            req_ready_i;
  logic [PC_W-1:0] req_addr_o;
  logic            resp_valid_i;
  logic            resp_ready_o;
  logic [31:0]     resp_inst_i;
  logic            resp_err_i;
  logic            f_valid_o;
  logic            D_ready_i;
  logic [31:0]     inst_o;
  logic [PC_W-1:0] pc_o;
  logic            fault_o;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;

  modport master (
    output req_valid_o, req_addr_o, resp_ready_o, f_valid_o, inst_o, pc_o, fault_o,
    input  req_ready_i, resp_valid_i, resp_inst_i, resp_err_i, D_ready_i,
           redirect_i, redirect_pc_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, resp_ready_o, f_valid_o, inst_o, pc_o, fault_o,
    output req_ready_i, resp_valid_i, resp_inst_i, resp_err_i, D_ready_i,
           redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory transaction, a single holding
// register toward decode, and redirect handling that drops in-flight responses.
module ifu #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h0000_0000_8000_0000)
) (
  input logic   clk_i,
  input logic   rst_i,
  ifu_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [PC_W-1:0] pc_out_q;
  logic            fault_q;

  logic req_fire;
  logic resp_fire;
  logic d_fire;
  logic keep_resp;

  assign bus.req_valid_o  = (state_q == S_REQ);
  assign bus.req_addr_o   = pc_q;
  assign bus.resp_ready_o = ((state_q == S_WAIT) || (state_q == S_DROP)) && !rst_i;
  assign bus.f_valid_o    = (state_q == S_HOLD) && !bus.redirect_i && !rst_i;
  assign bus.inst_o       = inst_q;
  assign bus.pc_o         = pc_out_q;
  assign bus.fault_o      = fault_q;

  assign req_fire  = bus.req_valid_o && bus.req_ready_i;
  assign resp_fire = bus.resp_valid_i && bus.resp_ready_o;
  assign d_fire    = bus.f_valid_o && bus.D_ready_i;
  // A response is only kept when it lands in WAIT without a simultaneous redirect.
  assign keep_resp = (state_q == S_WAIT) && resp_fire && !bus.redirect_i;

  // Next-state selection; redirect steers any in-flight transaction into DROP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (req_fire) state_d = bus.redirect_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (resp_fire)            state_d = bus.redirect_i ? S_REQ : S_HOLD;
        else if (bus.redirect_i)  state_d = S_DROP;
      end
      S_HOLD: begin
        if (bus.redirect_i || d_fire) state_d = S_REQ;
      end
      S_DROP: begin
        if (resp_fire) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and fetch PC; redirect wins over the sequential increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (bus.redirect_i)  pc_q <= bus.redirect_pc_i;
      else if (d_fire)     pc_q <= pc_q + PC_W'(4);
    end
  end

  // Decode holding register, written only by a kept response so it stays stable in HOLD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q   <= NOP_INST;
      pc_out_q <= '0;
      fault_q  <= 1'b0;
    end else if (keep_resp) begin
      inst_q   <= bus.resp_inst_i;
      pc_out_q <= pc_q;
      fault_q  <= bus.resp_err_i;
    end
  end
endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, zero-wait fetch, backpressure, redirect cases, wrap.
module tb_ifu;
  localparam int PC_W = 64;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  ifu_if #(.PC_W(PC_W)) bus ();

  ifu #(.PC_W(PC_W), .RESET_PC(RPC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_ready_i   = 1'b0;
    bus.resp_valid_i  = 1'b0;
    bus.resp_inst_i   = 32'h0;
    bus.resp_err_i    = 1'b0;
    bus.D_ready_i     = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;

    // Reset cycle: resp_ready and f_valid forced low, redirect overridden
    #1;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h1234;
    #1;
    chk("rst_resp_ready", bus.resp_ready_o, 0);
    chk("rst_f_valid", bus.f_valid_o, 0);
    step();
    step();
    rst = 1'b0; bus.redirect_i = 1'b0;
    #1;
    chk("rel_req_valid", bus.req_valid_o, 1);
    chk("rel_req_addr", bus.req_addr_o, RPC);
    chk("rel_f_valid", bus.f_valid_o, 0);
    chk("rel_inst", bus.inst_o, 64'h13);
    chk("rel_pc_o", bus.pc_o, 0);
    chk("rel_fault", bus.fault_o, 0);
    chk("rel_resp_ready", bus.resp_ready_o, 0);

    // Zero-wait fetch, first instruction
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h0010_0093;
    #1;
    chk("zw1_wait_resp_ready", bus.resp_ready_o, 1);
    chk("zw1_wait_f_valid", bus.f_valid_o, 0);
    step();
    bus.resp_valid_i = 1'b0;
    #1;
    chk("zw1_f_valid", bus.f_valid_o, 1);
    chk("zw1_inst", bus.inst_o, 64'h0010_0093);
    chk("zw1_pc_o", bus.pc_o, RPC);
    chk("zw1_fault", bus.fault_o, 0);
    step();
    #1;
    chk("zw2_req_addr", bus.req_addr_o, RPC + 4);
    chk("zw2_req_f_valid", bus.f_valid_o, 0);
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h0020_0113;
    step();
    bus.resp_valid_i = 1'b0;
    #1;
    chk("zw2_f_valid", bus.f_valid_o, 1);
    chk("zw2_inst", bus.inst_o, 64'h0020_0113);
    chk("zw2_pc_o", bus.pc_o, RPC + 4);
    step();

    // Backpressure: five cycles of D_ready low in HOLD
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h0030_0193;
    step();
    bus.resp_valid_i = 1'b0; bus.D_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_f_valid", bus.f_valid_o, 1);
      chk("bp_req_valid", bus.req_valid_o, 0);
      chk("bp_inst", bus.inst_o, 64'h0030_0193);
      chk("bp_pc_o", bus.pc_o, RPC + 8);
      chk("bp_fault", bus.fault_o, 0);
      step();
    end
    bus.D_ready_i = 1'b1;
    #1;
    chk("bp_release_f_valid", bus.f_valid_o, 1);
    step();
    #1;
    chk("bp_next_addr", bus.req_addr_o, RPC + 12);
    chk("bp_next_req_valid", bus.req_valid_o, 1);

    // Redirect in WAIT, stale response two cycles later
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0100;
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("rw_drop_req_valid", bus.req_valid_o, 0);
    chk("rw_drop_resp_ready", bus.resp_ready_o, 1);
    step();
    bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'hDEAD_BEEF;
    #1;
    chk("rw_drop_f_valid", bus.f_valid_o, 0);
    step();
    bus.resp_valid_i = 1'b0;
    #1;
    chk("rw_req_addr", bus.req_addr_o, 64'h8000_0100);
    chk("rw_req_valid", bus.req_valid_o, 1);
    chk("rw_inst_kept", bus.inst_o, 64'h0030_0193);
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h0040_0213;
    step();
    bus.resp_valid_i = 1'b0;
    #1;
    chk("rw_f_valid", bus.f_valid_o, 1);
    chk("rw_inst", bus.inst_o, 64'h0040_0213);
    chk("rw_pc_o", bus.pc_o, 64'h8000_0100);
    step();

    // Redirect coincident with the request handshake, then faulting fetch
    bus.req_ready_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0200;
    step();
    bus.req_ready_i = 1'b0; bus.redirect_i = 1'b0;
    #1;
    chk("rh_drop_req_valid", bus.req_valid_o, 0);
    chk("rh_drop_addr", bus.req_addr_o, 64'h8000_0200);
    bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h1111_1111;
    step();
    bus.resp_valid_i = 1'b0;
    #1;
    chk("rh_req_valid", bus.req_valid_o, 1);
    chk("rh_inst_kept", bus.inst_o, 64'h0040_0213);
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h0050_0293;
    bus.resp_err_i = 1'b1;
    step();
    bus.resp_valid_i = 1'b0; bus.resp_err_i = 1'b0;
    #1;
    chk("rh_f_valid", bus.f_valid_o, 1);
    chk("rh_fault", bus.fault_o, 1);
    chk("rh_pc_o", bus.pc_o, 64'h8000_0200);
    chk("rh_inst", bus.inst_o, 64'h0050_0293);
    step();

    // Redirect coincident with the response in WAIT
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h2222_2222;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0300;
    step();
    bus.resp_valid_i = 1'b0; bus.redirect_i = 1'b0;
    #1;
    chk("rr_f_valid", bus.f_valid_o, 0);
    chk("rr_req_valid", bus.req_valid_o, 1);
    chk("rr_req_addr", bus.req_addr_o, 64'h8000_0300);
    chk("rr_inst_kept", bus.inst_o, 64'h0050_0293);
    chk("rr_fault_kept", bus.fault_o, 1);

    // Redirect in HOLD suppresses the decode handshake
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h0060_0313;
    step();
    bus.resp_valid_i = 1'b0; bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0400;
    #1;
    chk("rhold_f_valid", bus.f_valid_o, 0);
    chk("rhold_fault", bus.fault_o, 0);
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("rhold_req_addr", bus.req_addr_o, 64'h8000_0400);
    chk("rhold_req_valid", bus.req_valid_o, 1);

    // PC wraps modulo 2^PC_W
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    bus.redirect_i = 1'b0; bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h0070_0393;
    step();
    bus.resp_valid_i = 1'b0;
    #1;
    chk("wrap_pc_o", bus.pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    #1;
    chk("wrap_req_addr", bus.req_addr_o, 64'h0);

    // Reset in WAIT with a response pending, then a stale response in REQ
    bus.req_ready_i = 1'b1;
    step();
    bus.req_ready_i = 1'b0; rst = 1'b1;
    #1;
    chk("rwait_resp_ready", bus.resp_ready_o, 0);
    step();
    rst = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_inst_i = 32'h3333_3333;
    #1;
    chk("rwait_req_valid", bus.req_valid_o, 1);
    chk("rwait_req_addr", bus.req_addr_o, RPC);
    chk("rwait_f_valid", bus.f_valid_o, 0);
    chk("rwait_resp_ready_req", bus.resp_ready_o, 0);
    chk("rwait_inst", bus.inst_o, 64'h13);
    step();
    bus.resp_valid_i = 1'b0;
    #1;
    chk("stale_req_valid", bus.req_valid_o, 1);
    chk("stale_f_valid", bus.f_valid_o, 0);
    chk("stale_inst", bus.inst_o, 64'h13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
